multicycle_core: RTL and testbench
==================================

Name: multicycle_core

Overview:
- Parametrised multicycle successor to the single-cycle 9-bit-ISA datapath.
- FSM-sequenced core with a start/done handshake and a HALT instruction.
- Instruction and data memories sit outside the block, each behind a req/ack interface that tolerates wait states.
- Branch and LUT constants come from an external combinational lookup port.
- Sits directly under the top level and replaces its ad-hoc PC/done logic.

Parameters:
- DW, 8: data/register width; memory address width = DW.
- PCW, 10: program counter width; PC wraps modulo 2^PCW.
- LUT_W, 10: lookup value width; zero-extended or truncated to DW or PCW at each use.
- CW, 16: cycle counter width.
- START_PC, 0: PC loaded on start.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-low (reset==0 resets on the clk edge).
- start, in, 1: level request to run the program.
- done, out, 1: program halted; held until start drops.
- busy, out, 1: high in FETCH/EXEC/MEM.
- imem_req, out, 1: instruction fetch request.
- imem_addr, out, PCW: fetch address = PC.
- imem_ack, in, 1: imem_data valid this cycle.
- imem_data, in, 9: instruction.
- dmem_req, out, 1: data access request.
- dmem_we, out, 1: 1 = store.
- dmem_addr, out, DW: data address.
- dmem_wdata, out, DW: store data.
- dmem_ack, in, 1: access complete; dmem_rdata valid.
- dmem_rdata, in, DW: load data.
- lut_idx, out, 5: lookup index.
- lut_val, in, LUT_W: lookup value (combinational).
- cycle_count, out, CW: cycles spent in busy states, saturating.

Behaviour:
- Reset: state=IDLE, PC=START_PC, R0-R3=0, flags eq=lt=0, IR=0, cycle_count=0. All outputs 0, except imem_addr=START_PC. A reset mid-access drops req the same edge; no write commits.
- IDLE: on start=1, PC<=START_PC, cycle_count<=0, go to FETCH.
- FETCH: imem_req=1, imem_addr=PC. On imem_ack, IR<=imem_data and go to EXEC. Unbounded wait otherwise.
- EXEC, R-type (00 ooo dd ss):
  - AND/OR/XOR/ADD/SUB: Rd<=Rd op Rs, mod 2^DW.
  - SLT/SLTE/SEQ: Rd<=zero-extended condition bit (unsigned compare).
  - Every R-op updates eq=(Rd==Rs) and lt=(Rd<Rs), using pre-op values.
- EXEC, M-type (01 ooo xxxx):
  - LL: R0<=lut_val, lut_idx={0,imm4}.
  - LIL: R0[3:0]<=imm4.
  - LIU: R0[7:4]<=imm4; other bits unchanged.
  - Opcodes 101-111 are NOP.
  - SB/LB go to MEM.
- EXEC, B-type (10 oo iiiii): lut_idx=iiiii. If the condition holds, PC<=lut_val (absolute); else PC+1. Conditions: BEQ uses eq, BLT uses lt, BLTE uses lt|eq, BUN is always taken.
- EXEC, S-type (11 oo ...):
  - LSL/LSR: Rd<=Rd shifted by Rs mod DW, zero fill.
  - BF: PC<=PC+lut_val.
  - BB: PC<=PC-lut_val.
  - Both wrap mod 2^PCW.
- HALT = 9'h1FF (BB index 31). It takes priority over BB: go to DONE, PC unchanged.
- Non-memory, non-branch instructions: PC<=PC+1, then FETCH.
- MEM: dmem_req=1, with addr/we/wdata held stable until ack.
  - SB: addr=R[dd], wdata=R[ss], we=1.
  - LB: addr=R[ss], we=0.
  - On dmem_ack, LB writes R[dd]<=dmem_rdata, PC<=PC+1, go to FETCH.
- DONE: done=1, busy=0. When start==0, go to IDLE and done<=0.
- Start held high across DONE does not restart the core.
- Latency: a non-memory instruction with zero-wait memory takes 2 cycles; a memory instruction takes 3 cycles; each wait cycle adds 1.
- cycle_count increments every cycle busy=1 and saturates at 2^CW-1.
- Simultaneous imem_ack on the final FETCH cycle and reset==0: reset wins.

Decomposition:
- Package core_pkg holds:
  - state enum {IDLE, FETCH, EXEC, MEM, DONE};
  - 2-bit type codes and opcode constants for each type;
  - HALT_INSTR = 9'h1FF.
- Sub-module core_alu (combinational, parametrised by DW): computes result, eq and lt for the R ops and the shifts.
- FSM, register file and PC live in multicycle_core.

Test Plan:
- Reset, then start=1 with program LIL 5, HALT and zero-wait memory → R0=8'h05; done rises after 4 busy cycles; cycle_count=4.
- R1=3, R2=3, SEQ R1,R2, then BEQ idx 2 with lut_val=10'h020 → R1=1; next imem_addr=0x020.
- SB with R0=0x40, R1=0xA5, dmem_ack delayed 3 cycles → dmem_req high 4 cycles; addr=0x40 and wdata=0xA5 stable throughout; PC+1 only after ack.
- PC=0x3FF executing ADD → next imem_addr=0x000 (wrap). BB with PC=2, lut_val=5 → PC=0x3FD.
- reset=0 asserted during a MEM wait → next edge: dmem_req=0, state IDLE, no register write, done=0.
- HALT reached with start held high → done stays 1 and no fetch occurs. Start then dropped → done=0 next cycle. Start raised again → fetch from START_PC.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_pkg
// Brief   : State encoding, instruction field codes and HALT word for the core
// Rev     : 1.0
// ============================================================================
package core_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] c_TYPE_R = 2'b00;
  localparam logic [1:0] c_TYPE_M = 2'b01;
  localparam logic [1:0] c_TYPE_B = 2'b10;
  localparam logic [1:0] c_TYPE_S = 2'b11;

  localparam logic [2:0] c_R_AND  = 3'd0;
  localparam logic [2:0] c_R_OR   = 3'd1;
  localparam logic [2:0] c_R_XOR  = 3'd2;
  localparam logic [2:0] c_R_ADD  = 3'd3;
  localparam logic [2:0] c_R_SUB  = 3'd4;
  localparam logic [2:0] c_R_SLT  = 3'd5;
  localparam logic [2:0] c_R_SLTE = 3'd6;
  localparam logic [2:0] c_R_SEQ  = 3'd7;

  localparam logic [2:0] c_M_LL   = 3'd0;
  localparam logic [2:0] c_M_LIL  = 3'd1;
  localparam logic [2:0] c_M_LIU  = 3'd2;
  localparam logic [2:0] c_M_SB   = 3'd3;
  localparam logic [2:0] c_M_LB   = 3'd4;

  localparam logic [1:0] c_B_BEQ  = 2'd0;
  localparam logic [1:0] c_B_BLT  = 2'd1;
  localparam logic [1:0] c_B_BLTE = 2'd2;
  localparam logic [1:0] c_B_BUN  = 2'd3;

  localparam logic [1:0] c_S_LSL  = 2'd0;
  localparam logic [1:0] c_S_LSR  = 2'd1;
  localparam logic [1:0] c_S_BF   = 2'd2;
  localparam logic [1:0] c_S_BB   = 2'd3;

  // ALU select: R ops use {0,ooo}, shifts use {100,dir}
  localparam logic [3:0] c_ALU_LSL = 4'b1000;
  localparam logic [3:0] c_ALU_LSR = 4'b1001;

  localparam logic [8:0] HALT_INSTR = 9'h1FF;

endpackage
`default_nettype wire

// File: rtl/core_alu.sv
`default_nettype none
// ============================================================================
// Module  : core_alu
// Brief   : Combinational ALU for R-type ops and shifts; eq/lt on raw operands
// Rev     : 1.0
// ============================================================================
module core_alu
  import core_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_res,
  output logic          o_eq,
  output logic          o_lt
);

  logic          w_eq;
  logic          w_lt;
  logic [DW-1:0] w_sh;

  assign w_eq = (i_a == i_b);
  assign w_lt = (i_a < i_b);
  assign w_sh = DW'(32'(i_b) % DW);
  assign o_eq = w_eq;
  assign o_lt = w_lt;

  always_comb begin
    o_res = '0;
    case (i_op)
      {1'b0, c_R_AND}:  o_res = i_a & i_b;
      {1'b0, c_R_OR}:   o_res = i_a | i_b;
      {1'b0, c_R_XOR}:  o_res = i_a ^ i_b;
      {1'b0, c_R_ADD}:  o_res = i_a + i_b;
      {1'b0, c_R_SUB}:  o_res = i_a - i_b;
      {1'b0, c_R_SLT}:  o_res = DW'(w_lt);
      {1'b0, c_R_SLTE}: o_res = DW'(w_lt | w_eq);
      {1'b0, c_R_SEQ}:  o_res = DW'(w_eq);
      c_ALU_LSL:        o_res = i_a << w_sh;
      c_ALU_LSR:        o_res = i_a >> w_sh;
      default:          o_res = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_core.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_core
// Brief   : FSM-sequenced 9-bit-ISA core with req/ack memories and LUT port
// Rev     : 1.0
// ============================================================================
module multicycle_core
  import core_pkg::*;
#(
  parameter int DW       = 8,
  parameter int PCW      = 10,
  parameter int LUT_W    = 10,
  parameter int CW       = 16,
  parameter int START_PC = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  output logic             busy,
  output logic             imem_req,
  output logic [PCW-1:0]   imem_addr,
  input  logic             imem_ack,
  input  logic [8:0]       imem_data,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [DW-1:0]    dmem_addr,
  output logic [DW-1:0]    dmem_wdata,
  input  logic             dmem_ack,
  input  logic [DW-1:0]    dmem_rdata,
  output logic [4:0]       lut_idx,
  input  logic [LUT_W-1:0] lut_val,
  output logic [CW-1:0]    cycle_count
);

  localparam logic [PCW-1:0] c_START = PCW'(START_PC);

  state_t         r_state;
  logic [PCW-1:0] r_pc;
  logic [DW-1:0]  r_regs [4];
  logic           r_eq, r_lt;
  logic [8:0]     r_ir;
  logic [CW-1:0]  r_cnt;
  logic           r_done, r_busy, r_imem_req, r_dmem_req, r_dmem_we;
  logic [DW-1:0]  r_dmem_addr, r_dmem_wdata;
  logic [4:0]     r_lut_idx;

  logic [1:0]     w_type, w_op2, w_dd, w_ss;
  logic [2:0]     w_op3;
  logic [3:0]     w_imm4, w_alu_op;
  logic [DW-1:0]  w_rd, w_rs, w_alu_res, w_lut_dw;
  logic           w_alu_eq, w_alu_lt, w_taken, w_is_mem;
  logic [PCW-1:0] w_lut_pc, w_pc_inc, w_pc_next;
  logic [4:0]     w_fetch_idx;

  assign w_type   = r_ir[8:7];
  assign w_op3    = r_ir[6:4];
  assign w_op2    = r_ir[6:5];
  assign w_dd     = r_ir[3:2];
  assign w_ss     = r_ir[1:0];
  assign w_imm4   = r_ir[3:0];
  assign w_rd     = r_regs[w_dd];
  assign w_rs     = r_regs[w_ss];
  assign w_alu_op = (w_type == c_TYPE_S) ? {3'b100, r_ir[5]} : {1'b0, w_op3};
  assign w_lut_dw = DW'(lut_val);
  assign w_lut_pc = PCW'(lut_val);
  assign w_pc_inc = r_pc + PCW'(1);
  assign w_is_mem = (w_type == c_TYPE_M) && ((w_op3 == c_M_SB) || (w_op3 == c_M_LB));

  core_alu #(.DW(DW)) u_alu (
    .i_op  (w_alu_op),
    .i_a   (w_rd),
    .i_b   (w_rs),
    .o_res (w_alu_res),
    .o_eq  (w_alu_eq),
    .o_lt  (w_alu_lt)
  );

  always_comb begin
    w_taken = 1'b0;
    case (w_op2)
      c_B_BEQ:  w_taken = r_eq;
      c_B_BLT:  w_taken = r_lt;
      c_B_BLTE: w_taken = r_lt | r_eq;
      default:  w_taken = 1'b1;
    endcase
  end

  always_comb begin
    w_pc_next = w_pc_inc;
    if (w_type == c_TYPE_B && w_taken)
      w_pc_next = w_lut_pc;
    else if (w_type == c_TYPE_S && w_op2 == c_S_BF)
      w_pc_next = r_pc + w_lut_pc;
    else if (w_type == c_TYPE_S && w_op2 == c_S_BB)
      w_pc_next = r_pc - w_lut_pc;
  end

  // Lookup index is captured with the instruction so lut_val is settled in EXEC
  always_comb begin
    w_fetch_idx = imem_data[4:0];
    case (imem_data[8:7])
      c_TYPE_R: w_fetch_idx = 5'd0;
      c_TYPE_M: w_fetch_idx = {1'b0, imem_data[3:0]};
      default:  w_fetch_idx = imem_data[4:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_pc         <= c_START;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      r_eq         <= 1'b0;
      r_lt         <= 1'b0;
      r_ir         <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_imem_req   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_lut_idx    <= '0;
    end else begin
      if (r_busy && (r_cnt != {CW{1'b1}})) r_cnt <= r_cnt + CW'(1);
      case (r_state)
        IDLE: if (start) begin
          r_pc       <= c_START;
          r_cnt      <= '0;
          r_busy     <= 1'b1;
          r_imem_req <= 1'b1;
          r_state    <= FETCH;
        end
        FETCH: if (imem_ack) begin
          r_ir       <= imem_data;
          r_lut_idx  <= w_fetch_idx;
          r_imem_req <= 1'b0;
          r_state    <= EXEC;
        end
        EXEC: begin
          if (r_ir == HALT_INSTR) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (w_is_mem) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= (w_op3 == c_M_SB);
            r_dmem_addr  <= (w_op3 == c_M_SB) ? w_rd : w_rs;
            r_dmem_wdata <= w_rs;
            r_state      <= MEM;
          end else begin
            r_pc       <= w_pc_next;
            r_imem_req <= 1'b1;
            r_state    <= FETCH;
            case (w_type)
              c_TYPE_R: begin
                r_regs[w_dd] <= w_alu_res;
                r_eq         <= w_alu_eq;
                r_lt         <= w_alu_lt;
              end
              c_TYPE_M: begin
                case (w_op3)
                  c_M_LL:  r_regs[0]      <= w_lut_dw;
                  c_M_LIL: r_regs[0][3:0] <= w_imm4;
                  c_M_LIU: r_regs[0][7:4] <= w_imm4;
                  default: ;
                endcase
              end
              c_TYPE_S: if (!r_ir[6]) r_regs[w_dd] <= w_alu_res;
              default: ;
            endcase
          end
        end
        MEM: if (dmem_ack) begin
          if (!r_dmem_we) r_regs[w_dd] <= dmem_rdata;
          r_dmem_req <= 1'b0;
          r_dmem_we  <= 1'b0;
          r_pc       <= w_pc_inc;
          r_imem_req <= 1'b1;
          r_state    <= FETCH;
        end
        DONE: if (!start) begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done        = r_done;
  assign busy        = r_busy;
  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign dmem_req    = r_dmem_req;
  assign dmem_we     = r_dmem_we;
  assign dmem_addr   = r_dmem_addr;
  assign dmem_wdata  = r_dmem_wdata;
  assign lut_idx     = r_lut_idx;
  assign cycle_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_core
// Brief   : Scoreboarded bench for multicycle_core with wait-state memories
// Rev     : 1.0
// ============================================================================
module tb_multicycle_core;

  localparam logic [8:0] HALT = 9'h1FF;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       done, busy, imem_req, dmem_req, dmem_we;
  logic [9:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [8:0] imem_data = '0;
  logic [7:0] dmem_addr, dmem_wdata;
  logic       dmem_ack = 1'b0;
  logic [7:0] dmem_rdata = '0;
  logic [4:0] lut_idx;
  logic [9:0] lut_val;
  logic [15:0] cycle_count;

  logic [8:0]  imem [1024];
  logic [7:0]  dmem [256];
  logic [9:0]  lut  [32];
  logic [15:0] exp_q [$];
  logic [9:0]  flog  [$];
  int imem_wait = 0, dmem_wait = 0, iw = 0, dw = 0;
  int n_checks = 0, n_errors = 0;

  multicycle_core dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .lut_idx(lut_idx), .lut_val(lut_val),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;
  assign lut_val = lut[lut_idx];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [8:0] i_r(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s);
    return {2'b00, op, d, s};
  endfunction
  function automatic logic [8:0] i_m(input logic [2:0] op, input logic [3:0] imm);
    return {2'b01, op, imm};
  endfunction
  function automatic logic [8:0] i_b(input logic [1:0] op, input logic [4:0] idx);
    return {2'b10, op, idx};
  endfunction
  function automatic logic [8:0] i_sh(input logic [1:0] op, input logic [1:0] d, input logic [1:0] s);
    return {2'b11, op, 1'b0, d, s};
  endfunction
  function automatic logic [8:0] i_sj(input logic [1:0] op, input logic [4:0] idx);
    return {2'b11, op, idx};
  endfunction

  // Memory responders: ack after a programmable number of wait cycles
  always @(negedge clk) begin
    if (imem_req) begin
      if (iw == imem_wait) begin
        imem_ack  = 1'b1;
        imem_data = imem[imem_addr];
        flog.push_back(imem_addr);
        iw = 0;
      end else begin
        imem_ack = 1'b0;
        iw++;
      end
    end else begin
      imem_ack = 1'b0;
      iw = 0;
    end
  end

  always @(negedge clk) begin
    if (dmem_req) begin
      if (dw == dmem_wait) begin
        dmem_ack = 1'b1;
        dw = 0;
        if (dmem_we) begin
          check("store_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("store", {dmem_addr, dmem_wdata}, exp_q.pop_front());
        end else begin
          dmem_rdata = dmem[dmem_addr];
        end
      end else begin
        dmem_ack = 1'b0;
        dw++;
      end
    end else begin
      dmem_ack = 1'b0;
      dw = 0;
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) imem[i] = HALT;
    flog.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_prog();
  endtask

  task automatic run_to_done(input int max_cyc, output int busy_cyc);
    int n = 0;
    busy_cyc = 0;
    start = 1'b1;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (busy) busy_cyc++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic end_run();
    start = 1'b0;
    @(negedge clk);
    check("done_cleared", done, 0);
    check("stores_left", exp_q.size(), 0);
  endtask

  task automatic wait_dreq();
    int n = 0;
    while (!dmem_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("dreq_seen", dmem_req, 1);
  endtask

  initial begin
    int bc, nf, nreq;
    for (int i = 0; i < 256; i++) dmem[i] = 8'(i * 7 + 1);
    for (int i = 0; i < 32; i++) lut[i] = '0;
    dmem[8'h33] = 8'h5A;
    dmem[8'h07] = 8'h99;
    lut[1] = 10'h3C7; lut[2] = 10'h020; lut[3] = 10'h00A; lut[4] = 10'd25;
    lut[5] = 10'd0;   lut[6] = 10'd3;   lut[7] = 10'h0A5; lut[8] = 10'h3FF;
    lut[9] = 10'd2;   lut[10] = 10'd5;

    // Reset state
    do_reset();
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ireq", imem_req, 0);
    check("rst_iaddr", imem_addr, 0);
    check("rst_dreq", dmem_req, 0);
    check("rst_dwe", dmem_we, 0);
    check("rst_lut_idx", lut_idx, 0);
    check("rst_count", cycle_count, 0);

    // LIL 5, HALT; then hold start across DONE
    imem[0] = i_m(3'd1, 4'd5);
    imem[1] = HALT;
    run_to_done(100, bc);
    check("halt_busy_cycles", bc, 4);
    check("halt_count", cycle_count, 4);
    nf = flog.size();
    repeat (5) begin
      @(negedge clk);
      check("hold_done", done, 1);
      check("hold_no_ireq", imem_req, 0);
    end
    check("hold_no_fetch", flog.size(), nf);
    end_run();
    check("idle_busy", busy, 0);
    // Restart from START_PC; registers survive across runs
    clear_prog();
    imem[0] = i_m(3'd3, {2'd0, 2'd0});
    exp_q.push_back({8'h05, 8'h05});
    start = 1'b1;
    @(negedge clk);
    check("restart_ireq", imem_req, 1);
    check("restart_addr", imem_addr, 0);
    run_to_done(100, bc);
    end_run();

    // SEQ then BEQ taken to lut value
    do_reset();
    imem[0] = i_m(3'd1, 4'd3);
    imem[1] = i_r(3'd1, 2'd1, 2'd0);
    imem[2] = i_r(3'd1, 2'd2, 2'd0);
    imem[3] = i_r(3'd7, 2'd1, 2'd2);
    imem[4] = i_b(2'd0, 5'd2);
    imem[5] = i_m(3'd3, {2'd0, 2'd0});
    imem[10'h020] = i_m(3'd3, {2'd2, 2'd1});
    exp_q.push_back({8'h03, 8'h01});
    run_to_done(200, bc);
    check("beq_target", flog.size() > 5 ? 32'(flog[5]) : 32'hFFFF, 10'h020);
    end_run();

    // Mixed ALU/LUT/shift/load/branch program with one-cycle fetch waits
    do_reset();
    imem_wait = 1;
    imem[0]  = i_m(3'd0, 4'd1);
    imem[1]  = i_r(3'd1, 2'd3, 2'd0);
    imem[2]  = i_m(3'd1, 4'd2);
    imem[3]  = i_m(3'd2, 4'd1);
    imem[4]  = i_r(3'd3, 2'd3, 2'd0);
    imem[5]  = i_m(3'd3, {2'd0, 2'd3});
    imem[6]  = i_r(3'd4, 2'd0, 2'd3);
    imem[7]  = i_b(2'd1, 5'd3);
    imem[8]  = i_m(3'd3, 4'd0);
    imem[10] = i_r(3'd2, 2'd3, 2'd0);
    imem[11] = i_m(3'd3, {2'd0, 2'd3});
    imem[12] = i_m(3'd1, 4'd3);
    imem[13] = i_sh(2'd1, 2'd3, 2'd0);
    imem[14] = i_m(3'd3, {2'd0, 2'd3});
    imem[15] = i_sh(2'd0, 2'd3, 2'd0);
    imem[16] = i_m(3'd3, {2'd0, 2'd3});
    imem[17] = i_m(3'd4, {2'd2, 2'd0});
    imem[18] = i_r(3'd5, 2'd2, 2'd3);
    imem[19] = i_m(3'd3, {2'd0, 2'd2});
    imem[20] = i_b(2'd2, 5'd4);
    imem[21] = i_m(3'd3, 4'd0);
    imem[25] = i_r(3'd6, 2'd3, 2'd0);
    imem[26] = i_m(3'd3, {2'd0, 2'd3});
    imem[27] = i_b(2'd0, 5'd5);
    imem[28] = i_sj(2'd2, 5'd6);
    imem[29] = i_m(3'd3, 4'd0);
    imem[31] = i_r(3'd0, 2'd0, 2'd0);
    imem[32] = i_m(3'd3, 4'd0);
    exp_q.push_back({8'h12, 8'hD9});
    exp_q.push_back({8'h39, 8'hE0});
    exp_q.push_back({8'h33, 8'h1C});
    exp_q.push_back({8'h33, 8'hE0});
    exp_q.push_back({8'h33, 8'h01});
    exp_q.push_back({8'h33, 8'h00});
    exp_q.push_back({8'h33, 8'h33});
    run_to_done(1000, bc);
    check("mix_count", cycle_count, 86);
    end_run();
    imem_wait = 0;

    // SB with three dmem wait cycles: stable request, PC held until ack
    do_reset();
    dmem_wait = 3;
    imem[0] = i_m(3'd0, 4'd7);
    imem[1] = i_r(3'd1, 2'd1, 2'd0);
    imem[2] = i_m(3'd1, 4'd0);
    imem[3] = i_m(3'd2, 4'd4);
    imem[4] = i_m(3'd3, {2'd0, 2'd1});
    exp_q.push_back({8'h40, 8'hA5});
    start = 1'b1;
    wait_dreq();
    nreq = 0;
    while (dmem_req && nreq < 20) begin
      check("sb_addr", dmem_addr, 8'h40);
      check("sb_wdata", dmem_wdata, 8'hA5);
      check("sb_we", dmem_we, 1);
      check("sb_pc_held", imem_addr, 4);
      nreq++;
      @(negedge clk);
    end
    check("sb_req_cycles", nreq, 4);
    run_to_done(100, bc);
    check("sb_next_fetch", flog.size() > 5 ? 32'(flog[5]) : 32'hFFFF, 5);
    end_run();
    dmem_wait = 0;

    // PC wrap at 0x3FF and BB below zero
    do_reset();
    imem[0]      = i_b(2'd0, 5'd9);
    imem[1]      = i_b(2'd3, 5'd8);
    imem[10'h3FF] = i_r(3'd3, 2'd0, 2'd0);
    imem[2]      = i_sj(2'd3, 5'd10);
    imem[3]      = i_m(3'd3, 4'd0);
    run_to_done(200, bc);
    check("wrap_fetch", flog.size() > 3 ? 32'(flog[3]) : 32'hFFFF, 0);
    check("bb_fetch", flog.size() > 5 ? 32'(flog[5]) : 32'hFFFF, 10'h3FD);
    check("bb_halt_pc", imem_addr, 10'h3FD);
    end_run();

    // Reset during a LB wait: request drops, nothing is written back
    do_reset();
    dmem_wait = 10;
    imem[0] = i_m(3'd1, 4'd7);
    imem[1] = i_m(3'd4, {2'd1, 2'd0});
    start = 1'b1;
    wait_dreq();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("mrst_dreq", dmem_req, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_ireq", imem_req, 0);
    check("mrst_iaddr", imem_addr, 0);
    reset = 1'b1;
    dmem_wait = 0;
    clear_prog();
    imem[0] = i_m(3'd3, {2'd1, 2'd1});
    exp_q.push_back({8'h00, 8'h00});
    run_to_done(100, bc);
    end_run();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
